// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
// Provides the flag bundle and the carry-segment sizing functions.
package adder_pkg;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } adder_flags_t;

  function automatic int seg_width(
    input int width,
    input int stages
  );
    return width / stages;
  endfunction

  function automatic bit seg_fits(
    input int width,
    input int stages
  );
    return (stages > 0) && (width >= 2)
      && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_seg.sv
// One carry segment: SEG-bit combinational ripple add.
// Ports: a, b, cin in; s, cout and c_msb (carry into bit SEG-1) out.
module adder_seg
  import adder_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           c_msb
);

  logic [SEG:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i])
             | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[SEG];
  assign c_msb = c[SEG-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract, carry chain split into STAGES segments.
// Ports: clk, rst, in_valid/in_ready, a, b, sub, cin,
//        out_valid/out_ready, sum, cout, ovf, zero, neg.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  if (!seg_fits(WIDTH, STAGES)) begin : g_bad
    $error("pipe_adder: WIDTH must be >= 2 and a multiple of STAGES");
  end

  logic             stall;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // a - b - cin == a + ~b + (1 - cin)
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub ^ cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // LW: operand bits still pending at this stage's input.
    // AW: sum bits complete after this stage.
    localparam int LW = WIDTH - k * SEG;
    localparam int AW = (k + 1) * SEG;

    logic [LW-1:0]  op_a;
    logic [LW-1:0]  op_b;
    logic           op_c;
    logic           op_v;
    logic [SEG-1:0] seg_s;
    logic           seg_co;
    logic           seg_cm;
    logic [AW-1:0]  acc;
    logic           v_q;
    logic [AW-1:0]  s_q;

    adder_seg #(
      .SEG (SEG)
    ) u_seg (
      .a     (op_a[SEG-1:0]),
      .b     (op_b[SEG-1:0]),
      .cin   (op_c),
      .s     (seg_s),
      .cout  (seg_co),
      .c_msb (seg_cm)
    );

    if (k == 0) begin : g_head
      assign op_a = a;
      assign op_b = b_eff;
      assign op_c = c0;
      assign op_v = accept;
      assign acc  = seg_s;
    end else begin : g_body
      assign op_a = g_st[k-1].g_fwd.a_q;
      assign op_b = g_st[k-1].g_fwd.b_q;
      assign op_c = g_st[k-1].g_fwd.c_q;
      assign op_v = g_st[k-1].v_q;
      assign acc  = {seg_s, g_st[k-1].s_q};
    end

    // Upper operand segments and the running carry ride along.
    if (k < STAGES - 1) begin : g_fwd
      logic [LW-SEG-1:0] a_q;
      logic [LW-SEG-1:0] b_q;
      logic              c_q;
      logic              cm_unused;

      assign cm_unused = seg_cm;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
        end else if (!stall) begin
          a_q <= op_a[LW-1:SEG];
          b_q <= op_b[LW-1:SEG];
          c_q <= seg_co;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        s_q <= '0;
      end else if (!stall) begin
        v_q <= op_v;
        s_q <= acc;
      end
    end
  end

  adder_flags_t flags_d;
  adder_flags_t flags_q;

  always_comb begin
    flags_d      = '0;
    flags_d.cout = g_st[STAGES-1].seg_co;
    flags_d.ovf  = g_st[STAGES-1].seg_cm
                 ^ g_st[STAGES-1].seg_co;
    flags_d.zero = (g_st[STAGES-1].acc == '0);
    flags_d.neg  = g_st[STAGES-1].acc[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else if (!stall) begin
      flags_q <= flags_d;
    end
  end

  assign out_valid = g_st[STAGES-1].v_q;
  assign sum       = g_st[STAGES-1].s_q;
  assign cout      = flags_q.cout;
  assign ovf       = flags_q.ovf;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: 32/4, 8/2 and 8/1 instances.
// Random and directed beats checked against an arithmetic model.
module tb_pipe_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        cin;
  logic        ordy;

  logic        ir0, ov0, co0, of0, z0, n0;
  logic [31:0] s0;
  logic        ir1, ov1, co1, of1, z1, n1;
  logic [7:0]  s1;
  logic        ir2, ov2, co2, of2, z2, n2;
  logic [7:0]  s2;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(32), .STAGES(4)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(ov0), .out_ready(ordy), .sum(s0),
    .cout(co0), .ovf(of0), .zero(z0), .neg(n0)
  );

  pipe_adder #(.WIDTH(8), .STAGES(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .a(a[7:0]), .b(b[7:0]), .sub(sub), .cin(cin),
    .out_valid(ov1), .out_ready(1'b1), .sum(s1),
    .cout(co1), .ovf(of1), .zero(z1), .neg(n1)
  );

  pipe_adder #(.WIDTH(8), .STAGES(1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
    .a(a[7:0]), .b(b[7:0]), .sub(sub), .cin(cin),
    .out_valid(ov2), .out_ready(1'b1), .sum(s2),
    .cout(co2), .ovf(of2), .zero(z2), .neg(n2)
  );

  logic        irdy_v[3];
  logic        ovld_v[3];
  logic        ordy_v[3];
  logic [35:0] res_v[3];

  assign irdy_v[0] = ir0;
  assign irdy_v[1] = ir1;
  assign irdy_v[2] = ir2;
  assign ovld_v[0] = ov0;
  assign ovld_v[1] = ov1;
  assign ovld_v[2] = ov2;
  assign ordy_v[0] = ordy;
  assign ordy_v[1] = 1'b1;
  assign ordy_v[2] = 1'b1;
  assign res_v[0]  = {s0, co0, of0, z0, n0};
  assign res_v[1]  = {24'h0, s1, co1, of1, z1, n1};
  assign res_v[2]  = {24'h0, s2, co2, of2, z2, n2};

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Result as {sum, cout, ovf, zero, neg} from integer arithmetic.
  function automatic logic [35:0] model(
    input int          w,
    input logic [31:0] xa,
    input logic [31:0] xb,
    input logic        xs,
    input logic        xc
  );
    longint m, half, ua, ub, sa, sb, cc, u, sv, r;
    logic co, ov, zr, ng;
    logic [31:0] r32;
    m    = longint'(1) << w;
    half = m / 2;
    ua   = longint'(xa) & (m - 1);
    ub   = longint'(xb) & (m - 1);
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    cc   = xc ? 1 : 0;
    if (xs) begin
      u  = ua - ub - cc;
      sv = sa - sb - cc;
      co = (u >= 0);
    end else begin
      u  = ua + ub + cc;
      sv = sa + sb + cc;
      co = (u >= m);
    end
    ov  = (sv < -half) || (sv >= half);
    r   = u & (m - 1);
    zr  = (r == 0);
    ng  = ((r >> (w - 1)) & 1) != 0;
    r32 = r[31:0];
    return {r32, co, ov, zr, ng};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  logic [35:0] q[3][$];
  int          tq[3][$];
  logic [35:0] held[3];
  bit          pst[3];
  int          n_out[3];
  int          st_seen = 0;
  int          stg[3] = '{4, 2, 1};
  int          wid[3] = '{32, 8, 8};

  // Scoreboard: push on accept, pop and compare on emit.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        q[i].delete();
        tq[i].delete();
        pst[i] = 1'b0;
      end else begin
        if (pst[i])
          check($sformatf("hold%0d", i), 64'(res_v[i]), 64'(held[i]));
        if (ovld_v[i] && !ordy_v[i]) begin
          check($sformatf("stall_irdy%0d", i), 64'(irdy_v[i]), 64'd0);
          held[i] = res_v[i];
          pst[i]  = 1'b1;
          if (i == 0) st_seen++;
        end else begin
          pst[i] = 1'b0;
        end
        if (ovld_v[i] && ordy_v[i]) begin
          if (q[i].size() == 0) begin
            check($sformatf("spurious%0d", i), 64'd1, 64'd0);
          end else begin
            logic [35:0] e;
            int t;
            e = q[i].pop_front();
            t = tq[i].pop_front();
            check($sformatf("res%0d", i), 64'(res_v[i]), 64'(e));
            if (i > 0)
              check($sformatf("lat%0d", i), 64'(cyc - t), 64'(stg[i]));
            n_out[i]++;
          end
        end
        if (in_valid && irdy_v[i]) begin
          q[i].push_back(model(wid[i], a, b, sub, cin));
          tq[i].push_back(cyc);
        end
      end
    end
  end

  task automatic send(
    input logic [31:0] xa,
    input logic [31:0] xb,
    input logic        xs,
    input logic        xc
  );
    int n;
    n = 0;
    in_valid = 1'b1;
    a = xa;
    b = xb;
    sub = xs;
    cin = xc;
    @(negedge clk);
    while (!ir0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic dir(
    input string       tag,
    input logic [31:0] xa,
    input logic [31:0] xb,
    input logic        xs,
    input logic        xc,
    input logic [35:0] exp
  );
    int lat;
    send(xa, xb, xs, xc);
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!ov0 && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check(tag, 64'(res_v[0]), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  bit done;

  initial begin
    int base_out, base_st, n, bad;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    cin = 1'b0;
    ordy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(ov0), 64'd0);
    check("rst_out", 64'(res_v[0]), 64'd0);
    check("rst_ready", 64'(ir0), 64'd1);
    check("rst_small", 64'({ov1, ov2, res_v[1], res_v[2]}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    dir("add_5_3",  32'd5, 32'd3, 1'b0, 1'b0, {32'd8, 4'b0000});
    dir("add_wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0,
        {32'd0, 4'b1010});
    dir("add_ovf",  32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0,
        {32'h8000_0000, 4'b0101});
    dir("sub_neg",  32'd3, 32'd5, 1'b1, 1'b0,
        {32'hFFFF_FFFE, 4'b0001});
    dir("sub_brw",  32'd10, 32'd3, 1'b1, 1'b1, {32'd6, 4'b1000});
    dir("sub_ovf",  32'h8000_0000, 32'd1, 1'b1, 1'b0,
        {32'h7FFF_FFFF, 4'b1100});

    // Back-to-back stream with a three-cycle output stall.
    base_out = n_out[0];
    base_st  = st_seen;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send($urandom, $urandom, 1'($urandom), 1'($urandom));
        in_valid = 1'b0;
      end
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!ov0 && w < 50) begin
          @(negedge clk);
          w++;
        end
        @(posedge clk);
        #1;
        ordy = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        ordy = 1'b1;
      end
    join
    n = 0;
    while (q[0].size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("stream_count", 64'(n_out[0] - base_out), 64'd8);
    check("stream_stall", 64'(st_seen - base_st), 64'd3);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++)
      send($urandom, $urandom, 1'($urandom), 1'($urandom));
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_valid", 64'(ov0), 64'd0);
    check("mid_rst_out", 64'(res_v[0]), 64'd0);
    check("mid_rst_ready", 64'(ir0), 64'd1);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov0 || ov1 || ov2) bad++;
    end
    check("no_partial", 64'(bad), 64'd0);
    @(posedge clk);
    #1;
    dir("post_rst", 32'd5, 32'd3, 1'b0, 1'b0, {32'd8, 4'b0000});

    // Random traffic with random backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          send(pick(), pick(), 1'($urandom), 1'($urandom));
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          ordy = ($urandom_range(3) != 0);
          @(posedge clk);
          #1;
        end
        ordy = 1'b1;
      end
    join
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0
           && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain0", 64'(q[0].size()), 64'd0);
    check("drain1", 64'(q[1].size()), 64'd0);
    check("drain2", 64'(q[2].size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined add/subtract unit for the RISC datapath. It is the successor to the single-cycle 32-bit combinational adder. The carry chain is split into `STAGES` registered segments, so wide adds close timing at the core clock. The block adds carry-in/borrow, subtract mode, condition flags and a valid/ready handshake with backpressure. It sits between operand fetch and writeback, beside the ALU, and feeds the branch-compare logic.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width in bits; must be ≥ 2.
- `STAGES`, 4: pipeline depth and number of carry segments; `WIDTH % STAGES == 0`; segment width `SEG = WIDTH/STAGES`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `in_valid`, in, 1: operand beat offered.
- `in_ready`, out, 1: block accepts the beat this cycle.
- `a`, in, WIDTH: operand A.
- `b`, in, WIDTH: operand B.
- `sub`, in, 1: 0 gives `a + b + cin`; 1 gives `a - b - cin`.
- `cin`, in, 1: carry-in (add) or borrow-in (sub).
- `out_valid`, out, 1: result beat present.
- `out_ready`, in, 1: consumer takes the result.
- `sum`, out, WIDTH: result.
- `cout`, out, 1: raw carry out of the MSB; in sub mode 1 means no borrow.
- `ovf`, out, 1: signed overflow.
- `zero`, out, 1: `sum == 0`.
- `neg`, out, 1: `sum[WIDTH-1]`.

## Operation
- Effective operands at entry:
  - `b_eff = sub ? ~b : b`
  - `c0 = sub ^ cin`, since `a - b - cin = a + ~b + (1 - cin)`.
- Segment arithmetic: stage k (0 = LSB segment) computes `{c_{k+1}, s_k} = a_k + b_eff_k + c_k` over `SEG` bits.
  - Already-computed lower sums travel forward in that stage's register.
  - Not-yet-used upper operand segments travel forward in the same register.
- Final stage:
  - `cout = c_STAGES`.
  - `ovf` = carry into bit WIDTH-1 XOR `cout`. The top segment adder also exposes its internal carry into the MSB.
  - `zero` and `neg` are derived from the full registered sum.
- Each pipeline register holds: a valid bit, partial sum, remaining operands and the running carry.
- Stall rule:
  - `stall = out_valid & ~out_ready`.
  - `in_ready = ~stall`.
  - While stalled, every stage register holds, including bubbles. There is no bubble collapsing.
- Transfers:
  - A beat enters when `in_valid & in_ready`.
  - It leaves when `out_valid & out_ready`.
  - With no stall, stage valid bits shift by one each cycle, and bubbles propagate as `valid = 0`.
- All arithmetic is modulo 2^WIDTH. Flags are registered together with `sum` and are meaningful only while `out_valid = 1`.

## Timing
- Latency: exactly `STAGES` cycles from the accept edge to `out_valid` rising, when there is no stall.
- Throughput: one beat per cycle while `out_ready = 1`.
- Reset: all stage valid bits go to 0, and `out_valid`, `sum`, `cout`, `ovf`, `zero` and `neg` go to 0.
  - `in_ready` is 1 during and after reset, because `out_valid = 0`.
  - Reset mid-operation discards all in-flight beats. No partial result ever appears.
- `out_valid & ~out_ready`: `sum` and all flags hold stable until the transfer completes.
- `in_ready` depends combinationally on `out_ready`. This is the only comb input-to-output path.
- Simultaneous accept and emit in one cycle is legal, with full overlap.
- An `in_valid` beat offered while `in_ready = 0` is not captured. The producer must hold it.
- `STAGES = 1`: the block degenerates to a single registered adder with latency 1.

## Structure
- Package `adder_pkg`:
  - `adder_flags_t` struct with fields {cout, ovf, zero, neg}.
  - Localparam function for `SEG`.
  - Elaboration check: `WIDTH % STAGES == 0`.
- Sub-module `adder_seg`, parameter `SEG`:
  - Combinational `SEG`-bit ripple add.
  - Ports a, b, cin, s, cout, plus `c_msb`, the carry into its top bit.
  - The top layer instantiates `STAGES` copies with pipeline registers between them.

## Test plan
- Reset, then `a = 5`, `b = 3`, `sub = 0`, `cin = 0` → after 4 cycles: `sum = 8`, `cout = 0`, `ovf = 0`, `zero = 0`, `neg = 0`.
- `a = 0xFFFFFFFF`, `b = 1`, add → `sum = 0`, `cout = 1`, `zero = 1`, `ovf = 0`. This checks carry across all segment boundaries.
- `a = 0x7FFFFFFF`, `b = 1`, add → `sum = 0x80000000`, `ovf = 1`, `neg = 1`.
- `a = 3`, `b = 5`, `sub = 1`, `cin = 0` → `sum = 0xFFFFFFFE`, `cout = 0`, `neg = 1`. Then `a = 10`, `b = 3`, `sub = 1`, `cin = 1` → `sum = 6`, `cout = 1`.
- Back-to-back stream of 8 beats, with `out_ready` low for 3 cycles mid-stream → no loss or duplication, results in order, `sum` stable while stalled, `in_ready = 0` while stalled.
- Assert `rst` with 3 beats in flight → all valid bits and outputs 0 on the next edge, and the next accepted beat emerges with correct latency. Repeat the directed cases with `WIDTH = 8`, `STAGES = 2` and with `STAGES = 1`.
